// File: rtl/seg_sched_pkg.sv
// Shared types and helpers for the 7-segment display frame scheduler.
package seg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    SHIFT
  } sched_state_t;

  localparam int HEX_W   = 32;
  localparam int POINT_W = 8;
  localparam int LES_W   = 8;
  localparam int SW_W    = 1;

  // LSB position of client idx inside a packed per-client bus of the given field width.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/seg_rr_arb.sv
// Frame-owner arbiter: combinational pick plus registered round-robin pointer.
// Build option SSEG_SCHED_PRIO_EN replaces round-robin with fixed lowest-index priority.
module seg_rr_arb
  import seg_sched_pkg::*;
#(
  parameter int N_CLIENTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CLIENTS-1:0] req,
  input  logic                 advance,
  output logic [N_CLIENTS-1:0] sel,
  output logic                 valid
);

  assign valid = |req;

`ifdef SSEG_SCHED_PRIO_EN
  logic unused_ctrl;
  assign unused_ctrl = clk ^ rst ^ advance;

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_prio
    localparam logic [N_CLIENTS-1:0] LOWER_MASK = N_CLIENTS'((1 << gi) - 1);
    assign sel[gi] = req[gi] & ~(|(req & LOWER_MASK));
  end
`else
  localparam int PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic             found;

  // ptr_reg holds the first index to consider; the second pass handles the wrap to 0.
  always_comb begin
    sel      = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (!found && req[i] && (PTR_W'(i) >= ptr_reg)) begin
        sel[i]   = 1'b1;
        found    = 1'b1;
        ptr_next = (i == N_CLIENTS - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (!found && req[i]) begin
        sel[i]   = 1'b1;
        found    = 1'b1;
        ptr_next = (i == N_CLIENTS - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else if (advance && valid) begin
      ptr_reg <= ptr_next;
    end
  end
`endif

endmodule

// File: rtl/seg_disp_sched.sv
// Time-shares the serial 7-segment shifter among N_CLIENTS frame producers.
// Build option SSEG_SCHED_PRIO_EN selects fixed-priority arbitration (see seg_rr_arb).
module seg_disp_sched
  import seg_sched_pkg::*;
#(
  parameter int N_CLIENTS      = 2,
  parameter int REFRESH_CYCLES = 50000,
  parameter int SHIFT_CYCLES   = 160
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CLIENTS-1:0]           req,
  input  logic [HEX_W*N_CLIENTS-1:0]     c_hexs,
  input  logic [POINT_W*N_CLIENTS-1:0]   c_point,
  input  logic [LES_W*N_CLIENTS-1:0]     c_les,
  input  logic [N_CLIENTS-1:0]           c_txt,
  output logic [HEX_W-1:0]               Hexs,
  output logic [POINT_W-1:0]             point,
  output logic [LES_W-1:0]               LES,
  output logic                           SW0,
  output logic                           Start,
  output logic [N_CLIENTS-1:0]           grant,
  output logic                           busy
);

  localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int SFT_W = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [SFT_W-1:0] SFT_LAST = SFT_W'(SHIFT_CYCLES - 1);

  sched_state_t         state_reg;
  logic [TMR_W-1:0]     timer_reg;
  logic [SFT_W-1:0]     shift_cnt_reg;
  logic                 pending_reg;
  logic [HEX_W-1:0]     hexs_reg;
  logic [POINT_W-1:0]   point_reg;
  logic [LES_W-1:0]     les_reg;
  logic                 sw0_reg;
  logic                 start_reg;
  logic                 busy_reg;
  logic [N_CLIENTS-1:0] grant_reg;

  logic                 timer_wrap;
  logic                 arb_advance;
  logic                 arb_valid;
  logic [N_CLIENTS-1:0] arb_sel;
  logic [N_CLIENTS-1:0] owner_oh;

  logic [N_CLIENTS-1:0][HEX_W-1:0]   hex_terms;
  logic [N_CLIENTS-1:0][POINT_W-1:0] point_terms;
  logic [N_CLIENTS-1:0][LES_W-1:0]   les_terms;
  logic [HEX_W-1:0]                  hex_next;
  logic [POINT_W-1:0]                point_next;
  logic [LES_W-1:0]                  les_next;
  logic                              sw0_next;

  assign timer_wrap  = (timer_reg == TMR_LAST);
  assign arb_advance = (state_reg == LOAD);
  // With nobody requesting, the last owner is refreshed; a zero grant yields an all-zero frame.
  assign owner_oh    = arb_valid ? arb_sel : grant_reg;

  seg_rr_arb #(
    .N_CLIENTS(N_CLIENTS)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (arb_advance),
    .sel     (arb_sel),
    .valid   (arb_valid)
  );

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_frame
    assign hex_terms[gi]   = owner_oh[gi] ? c_hexs[slice_lsb(gi, HEX_W) +: HEX_W] : '0;
    assign point_terms[gi] = owner_oh[gi] ? c_point[slice_lsb(gi, POINT_W) +: POINT_W] : '0;
    assign les_terms[gi]   = owner_oh[gi] ? c_les[slice_lsb(gi, LES_W) +: LES_W] : '0;
  end

  always_comb begin
    hex_next   = '0;
    point_next = '0;
    les_next   = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      hex_next   = hex_next | hex_terms[i];
      point_next = point_next | point_terms[i];
      les_next   = les_next | les_terms[i];
    end
    sw0_next = |(owner_oh & c_txt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      shift_cnt_reg <= '0;
      pending_reg   <= 1'b0;
      hexs_reg      <= '0;
      point_reg     <= '0;
      les_reg       <= '0;
      sw0_reg       <= 1'b0;
      start_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      grant_reg     <= '0;
    end else begin
      timer_reg   <= timer_wrap ? '0 : timer_reg + TMR_W'(1);
      // A wrap on the LOAD-entry edge wins over the clear, so no refresh slot is dropped.
      pending_reg <= timer_wrap | (pending_reg & (state_reg != IDLE));
      start_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pending_reg) begin
            state_reg <= LOAD;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          hexs_reg  <= hex_next;
          point_reg <= point_next;
          les_reg   <= les_next;
          sw0_reg   <= sw0_next;
          grant_reg <= owner_oh;
          start_reg <= 1'b1;
          state_reg <= START;
        end
        START: begin
          shift_cnt_reg <= '0;
          state_reg     <= SHIFT;
        end
        SHIFT: begin
          if (shift_cnt_reg == SFT_LAST) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            shift_cnt_reg <= shift_cnt_reg + SFT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Hexs  = hexs_reg;
  assign point = point_reg;
  assign LES   = les_reg;
  assign SW0   = sw0_reg;
  assign Start = start_reg;
  assign grant = grant_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Bench for seg_disp_sched: two instances (slow refresh and back-to-back refresh)
// checked every cycle against a slot-timing and arbitration reference model.
module tb_seg_disp_sched;

  localparam int N = 3;
  localparam int RP [2] = '{20, 4};
  localparam int SP [2] = '{8, 10};

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [32*N-1:0] c_hexs;
  logic [8*N-1:0]  c_point;
  logic [8*N-1:0]  c_les;
  logic [N-1:0]    c_txt;

  logic [31:0]  hexs_w  [2];
  logic [7:0]   point_w [2];
  logic [7:0]   les_w   [2];
  logic [N-1:0] grant_w [2];
  logic [1:0]   sw_w;
  logic [1:0]   start_w;
  logic [1:0]   busy_w;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state, one slot per instance.
  int          last_t     [2];
  int          earliest   [2];
  int          owner      [2];
  int          rr         [2];
  int          prev_start [2];
  bit          first_seen [2];
  logic [31:0] e_hexs     [2];
  logic [7:0]  e_point    [2];
  logic [7:0]  e_les      [2];
  logic        e_sw       [2];

  always #5 clk = ~clk;

  seg_disp_sched #(.N_CLIENTS(N), .REFRESH_CYCLES(20), .SHIFT_CYCLES(8)) u_rr (
    .clk(clk), .rst(rst), .req(req), .c_hexs(c_hexs), .c_point(c_point), .c_les(c_les),
    .c_txt(c_txt), .Hexs(hexs_w[0]), .point(point_w[0]), .LES(les_w[0]), .SW0(sw_w[0]),
    .Start(start_w[0]), .grant(grant_w[0]), .busy(busy_w[0])
  );

  seg_disp_sched #(.N_CLIENTS(N), .REFRESH_CYCLES(4), .SHIFT_CYCLES(10)) u_bb (
    .clk(clk), .rst(rst), .req(req), .c_hexs(c_hexs), .c_point(c_point), .c_les(c_les),
    .c_txt(c_txt), .Hexs(hexs_w[1]), .point(point_w[1]), .LES(les_w[1]), .SW0(sw_w[1]),
    .Start(start_w[1]), .grant(grant_w[1]), .busy(busy_w[1])
  );

  task automatic check(input string tag, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", tag, k, cyc, got, exp);
    end
  endtask

  // Frames start 3 cycles after the oldest unserved wrap, but no sooner than
  // SHIFT+3 cycles after the previous Start; the owner is chosen from the
  // request seen in the LOAD cycle just before Start.
  task automatic model_and_check();
    for (int k = 0; k < 2; k++) begin
      int nt;
      bit exp_start;
      bit exp_busy;
      if (!rst) begin
        last_t[k] = -1000; earliest[k] = -1; owner[k] = -1; rr[k] = 0;
        prev_start[k] = -1; first_seen[k] = 1'b0;
        e_hexs[k] = '0; e_point[k] = '0; e_les[k] = '0; e_sw[k] = 1'b0;
      end
      if ((cyc % RP[k]) == RP[k] - 1 && earliest[k] < 0) earliest[k] = cyc;
      if (earliest[k] < 0) nt = 32'h3fff_ffff;
      else if (earliest[k] + 3 > last_t[k] + SP[k] + 3) nt = earliest[k] + 3;
      else nt = last_t[k] + SP[k] + 3;
      exp_start = (cyc == nt);
      if (exp_start) begin
        if (req != '0) begin
          for (int i = 0; i < N; i++) begin
            int cand;
`ifdef SSEG_SCHED_PRIO_EN
            cand = i;
`else
            cand = (rr[k] + i) % N;
`endif
            if (req[cand]) begin
              owner[k] = cand;
              break;
            end
          end
          rr[k] = (owner[k] + 1) % N;
        end
        if (owner[k] >= 0) begin
          e_hexs[k]  = c_hexs[32*owner[k] +: 32];
          e_point[k] = c_point[8*owner[k] +: 8];
          e_les[k]   = c_les[8*owner[k] +: 8];
          e_sw[k]    = c_txt[owner[k]];
        end
        last_t[k]   = cyc;
        earliest[k] = -1;
        for (int w = cyc - 2; w <= cyc; w++)
          if (w >= 0 && (w % RP[k]) == RP[k] - 1 && earliest[k] < 0) earliest[k] = w;
      end
      exp_busy = (cyc >= last_t[k] && cyc <= last_t[k] + SP[k]) || (cyc == nt - 1);

      check("start", k, 32'(start_w[k]), 32'(exp_start));
      check("busy",  k, 32'(busy_w[k]),  32'(exp_busy));
      check("hexs",  k, hexs_w[k], e_hexs[k]);
      check("point", k, 32'(point_w[k]), 32'(e_point[k]));
      check("les",   k, 32'(les_w[k]),   32'(e_les[k]));
      check("sw0",   k, 32'(sw_w[k]),    32'(e_sw[k]));
      check("grant", k, 32'(grant_w[k]), (owner[k] >= 0) ? (32'd1 << owner[k]) : 32'd0);

      if (rst && start_w[k]) begin
        if (!first_seen[k]) begin
          first_seen[k] = 1'b1;
          check("first_start_cycle", k, cyc, RP[k] + 2);
        end
        if (k == 1 && prev_start[k] >= 0) check("b2b_spacing", k, cyc - prev_start[k], SP[k] + 3);
        prev_start[k] = cyc;
      end
    end
  endtask

  // mode 0: hold inputs; 1: random req and data; 2: random data only
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (!rst) cyc = 0;
      else cyc++;
      model_and_check();
      if (mode == 1) req = N'($urandom_range(0, 7));
      if (mode != 0) begin
        c_hexs  = {$urandom, $urandom, $urandom};
        c_point = 24'($urandom);
        c_les   = 24'($urandom);
        c_txt   = N'($urandom);
      end
    end
  endtask

  initial begin
    int waited;
    rst     = 1'b0;
    req     = '0;
    c_hexs  = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    c_point = {8'h04, 8'h02, 8'h01};
    c_les   = {8'h40, 8'h20, 8'h10};
    c_txt   = 3'b010;
    run(4, 0);

    rst = 1'b1;                 // no owner yet: zero frames still refreshed
    run(60, 0);
    req = 3'b011;               // round-robin between clients 0 and 1
    run(120, 0);
    c_hexs[31:0] = 32'h12345678;
    run(40, 0);
    req = 3'b000;               // last owner is re-sent
    run(60, 0);
    run(400, 1);

    waited = 0;
    while (!start_w[0] && waited < 100) begin
      run(1, 0);
      waited++;
    end
    check("wait_start", 0, 32'(start_w[0]), 32'd1);
    run(3, 0);
    rst = 1'b0;                 // abort mid-shift
    run(5, 0);
    rst = 1'b1;
    req = 3'b111;
    run(40, 0);
    run(300, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
